// File: rtl/norm_shift_seq.sv
// Iterative normalization shifter: left-shifts the unrounded fraction up to STEP bits per cycle.
// Result valid 1+ceil(s/STEP) cycles after capture; accepts only in IDLE, holds the result until out_ready.
module norm_shift_seq #(
  parameter int STEP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [56:0] fr_in,
  input  logic [12:0] er_in,
  input  logic        db_in,
  input  logic        tiny_in,
  input  logic        ovf1_in,
  input  logic [5:0]  lz_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [56:0] fn_out,
  output logic [12:0] en_out,
  output logic        db_out,
  output logic        tiny_out,
  output logic        ovf_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state_q, state_d;
  logic [56:0] fn_q, fn_d;
  logic [12:0] en_q, en_d;
  logic        db_q, db_d;
  logic        tiny_q, tiny_d;
  logic        ovf_q, ovf_d;
  logic [5:0]  rem_q, rem_d;

  logic signed [12:0] emin, emax;
  logic [13:0]        diff;
  logic [5:0]         cap_s;
  logic [56:0]        cap_fn;
  logic [12:0]        cap_en;
  logic               cap_ovf;
  logic [5:0]         d;

  // Operand decode at capture: the exponent is final here, only the fraction is shifted later.
  always_comb begin
    emin   = db_in ? -13'sd1022 : -13'sd126;
    emax   = db_in ? 13'sd1023 : 13'sd127;
    diff   = {er_in[12], er_in} - {emin[12], emin};
    cap_s  = 6'd0;
    cap_fn = fr_in;
    cap_en = er_in;
    if (fr_in == 57'd0) begin
      cap_fn = 57'd0;
      cap_en = 13'd0;
    end else if (ovf1_in) begin
      cap_fn = {1'b0, fr_in[56:2], fr_in[1] | fr_in[0]};
      cap_en = er_in + 13'd1;
    end else begin
      if (!tiny_in)
        cap_s = lz_in;
      else if (diff[13])
        cap_s = 6'd0;
      else if (diff < {8'd0, lz_in})
        cap_s = diff[5:0];
      else
        cap_s = lz_in;
      cap_en = er_in - {7'd0, cap_s};
    end
    cap_ovf = $signed(cap_en) > emax;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fn_q    <= 57'd0;
      en_q    <= 13'd0;
      db_q    <= 1'b0;
      tiny_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rem_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      fn_q    <= fn_d;
      en_q    <= en_d;
      db_q    <= db_d;
      tiny_q  <= tiny_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fn_d    = fn_q;
    en_d    = en_q;
    db_d    = db_q;
    tiny_d  = tiny_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    d       = (rem_q > STEP_W) ? STEP_W : rem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          fn_d    = cap_fn;
          en_d    = cap_en;
          db_d    = db_in;
          tiny_d  = tiny_in;
          ovf_d   = cap_ovf;
          rem_d   = cap_s;
          state_d = (cap_s == 6'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        fn_d  = fn_q << d;
        rem_d = rem_q - d;
        if (rem_d == 6'd0)
          state_d = DONE;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign fn_out    = fn_q;
  assign en_out    = en_q;
  assign db_out    = db_q;
  assign tiny_out  = tiny_q;
  assign ovf_out   = ovf_q;

endmodule

// File: doc/norm_shift_seq.md
# norm_shift_seq

Multi-cycle normalization shifter for the rounder path. It sits directly after `flags` and consumes that block's outputs: the unrounded fraction/exponent and the TINY, OVF1 and lz indications. From these it produces the normalized fraction and adjusted exponent that feed significand rounding. Shifting is iterative, at most STEP bit positions per cycle, to keep the 57-bit shifter small. Valid/ready handshakes are used on both sides.

## Interface
- STEP, 16, maximum left-shift distance applied per SHIFT cycle (power of two, 1..32)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream presents an operand
- in_ready  out  1  block can accept; high exactly when state is IDLE
- fr_in  in  57  unrounded fraction, bit 56 = 2^1 weight, bit 55 = hidden-bit position
- er_in  in  13  exponent, two's complement, unbiased
- db_in  in  1  1 = double (emin −1022, emax 1023), 0 = single (emin −126, emax 127)
- tiny_in  in  1  TINY from `flags`
- ovf1_in  in  1  OVF1 from `flags` (fr_in ≥ 2)
- lz_in  in  6  leading zeros of fr_in[55:0] (56 when zero)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- fn_out  out  57  normalized fraction
- en_out  out  13  adjusted exponent, two's complement
- db_out  out  1  registered db_in
- tiny_out  out  1  registered tiny_in
- ovf_out  out  1  en_out > emax(db)

## Operation
- States: IDLE, SHIFT, DONE. Registers: fraction, exponent, 6-bit remaining-shift count rem, format, flags.
- IDLE, in_valid&in_ready: capture operand; compute shift amount s and next state, priority order:
  - fr_in == 0: fn=0, en=0, → DONE.
  - ovf1_in: right shift by 1, with the shifted-out bit ORed into bit 0 (sticky); en = er_in+1; → DONE. Takes priority over tiny_in.
  - tiny_in: s = min(lz_in, max(0, er_in − emin)); en = er_in − s.
  - otherwise: s = lz_in; en = er_in − s.
  - s == 0 → DONE; else rem = s → SHIFT.
- SHIFT: each cycle, left shift fraction by d = min(rem, STEP), rem −= d; when rem reaches 0 → DONE. Zeros fill from bit 0. The exponent is already final at capture.
- DONE: out_valid=1, outputs stable; on out_ready → IDLE.
- ovf_out is computed with a signed compare of the final en against emax(db).
- Exponent arithmetic is 13-bit two's complement. No saturation is performed, because the input range guarantees no wrap.
- in_valid is ignored outside IDLE. No operand is ever dropped once accepted.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, fn_out=0, en_out=0, db_out=0, tiny_out=0, ovf_out=0, rem=0.
- rst has priority over all events. Asserting it mid-SHIFT or mid-DONE discards the operand. The block is in IDLE in the cycle after the reset edge.
- Handshake in cycle k → out_valid high from cycle k+1+ceil(s/STEP). The zero, OVF1 and s=0 paths give k+1.
- in_ready is low from k+1 until the cycle after the output handshake. Throughput is one operand per (2+ceil(s/STEP)) cycles minimum.
- out_valid stays high and all outputs are held, unchanged, until out_ready is sampled high. out_valid drops in the next cycle.
- Outputs change only on the capture edge, SHIFT edges and the reset edge. Values during SHIFT are intermediate and must not be consumed (out_valid=0).

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0 throughout, in_ready=1 the cycle after release, all outputs 0, no capture.
- Already normalized: fr_in=1<<55, lz_in=0, er_in=5, db_in=1 → out_valid at k+1, fn_out=1<<55, en_out=5, ovf_out=0.
- Long shift: fr_in=1<<20, lz_in=35, er_in=100, db_in=1, STEP=16 → out_valid at k+4 (3 SHIFT cycles), fn_out=1<<55, en_out=65.
- OVF1 with sticky: fr_in=(1<<56)|1, ovf1_in=1, er_in=127, db_in=0 → out_valid k+1, fn_out=(1<<55)|1, en_out=128, ovf_out=1.
- Tiny clamp: db_in=0, er_in=−120, fr_in=1<<40, lz_in=15, tiny_in=1 → s=6, out_valid k+2, fn_out=1<<46, en_out=−126, tiny_out=1.
- Backpressure: out_ready=0 for 5 cycles in DONE while a second operand is driven → outputs bit-stable, in_ready=0, second operand not captured. Raise out_ready → in_ready=1 next cycle, second operand accepted and processed correctly.
